// File: rtl/bcd_entry_register.sv
// bcd_entry_register
// Multi-digit BCD operand register for the keypad path. Digits shift in at
// the least significant digit; supports backspace, sign toggle, parallel
// load from the ALU result bus and synchronous clear. Tracks the number of
// significant digits and pulses err for one cycle on a rejected request.
//
// Request handling: every request input is sampled on the rising edge of
// clk, there is no handshake back-pressure, and the result of a request is
// visible on the outputs one cycle later.

module bcd_entry_register #(
    parameter int DIGITS = 8,
    parameter int CW     = $clog2(DIGITS + 1)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  clr,
    input  logic                  digit_vld,
    input  logic [3:0]            digit_in,
    input  logic                  bksp,
    input  logic                  neg_tgl,
    input  logic                  load,
    input  logic [4*DIGITS-1:0]   load_val,
    input  logic                  load_neg,
    output logic [4*DIGITS-1:0]   value,
    output logic                  neg,
    output logic [CW-1:0]         count,
    output logic                  full,
    output logic                  err
);

    logic [4*DIGITS-1:0] r_val;
    logic [CW-1:0]       r_cnt;
    logic                r_neg;
    logic                r_err;

    logic                w_full;
    logic                w_load_bad;
    logic [CW-1:0]       w_load_cnt;
    logic [4*DIGITS-1:0] w_nxt_val;
    logic [CW-1:0]       w_nxt_cnt;
    logic                w_nxt_neg;
    logic                w_nxt_err;

    assign w_full = (r_cnt == CW'(DIGITS));

    // Scan the load bus: reject non-BCD nibbles, find the highest nonzero digit.
    always_comb begin
        w_load_bad = 1'b0;
        w_load_cnt = '0;
        for (int i = 0; i < DIGITS; i++) begin
            if (load_val[4*i +: 4] > 4'd9) begin
                w_load_bad = 1'b1;
            end
            if (load_val[4*i +: 4] != 4'd0) begin
                w_load_cnt = CW'(i + 1);
            end
        end
    end

    // Next-state selection: clr > load > bksp > digit push, then the sign toggle.
    always_comb begin
        w_nxt_val = r_val;
        w_nxt_cnt = r_cnt;
        w_nxt_neg = r_neg;
        w_nxt_err = 1'b0;
        if (clr) begin
            w_nxt_val = '0;
            w_nxt_cnt = '0;
            w_nxt_neg = 1'b0;
        end else if (load) begin
            if (w_load_bad) begin
                w_nxt_err = 1'b1;
            end else begin
                w_nxt_val = load_val;
                w_nxt_cnt = w_load_cnt;
                w_nxt_neg = load_neg & (w_load_cnt != '0);
            end
        end else begin
            if (bksp) begin
                // Backspace on an empty register is a silent no-op.
                if (r_cnt != '0) begin
                    w_nxt_val = {4'd0, r_val[4*DIGITS-1:4]};
                    w_nxt_cnt = r_cnt - CW'(1);
                end
            end else if (digit_vld) begin
                if ((digit_in > 4'd9) || w_full) begin
                    w_nxt_err = 1'b1;
                end else if ((r_cnt == '0) && (digit_in == 4'd0)) begin
                    // Leading zero suppressed: register stays empty.
                    w_nxt_val = r_val;
                end else begin
                    w_nxt_val = {r_val[4*DIGITS-5:0], digit_in};
                    w_nxt_cnt = r_cnt + CW'(1);
                end
            end
            // Zero is never negative; toggle only applies to a nonzero result.
            if (w_nxt_cnt == '0) begin
                w_nxt_neg = 1'b0;
            end else if (neg_tgl) begin
                w_nxt_neg = ~r_neg;
            end
        end
    end

    // State registers with asynchronous active-high reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_val <= '0;
            r_cnt <= '0;
            r_neg <= 1'b0;
            r_err <= 1'b0;
        end else begin
            r_val <= w_nxt_val;
            r_cnt <= w_nxt_cnt;
            r_neg <= w_nxt_neg;
            r_err <= w_nxt_err;
        end
    end

    assign value = r_val;
    assign neg   = r_neg;
    assign count = r_cnt;
    assign full  = w_full;
    assign err   = r_err;

endmodule

// File: tb/tb_bcd_entry_register.sv
// Testbench for bcd_entry_register (DIGITS = 8). The reference model keeps
// the operand as a plain decimal integer; count is its number of decimal
// digits and value is its BCD encoding.

module tb_bcd_entry_register;

    localparam int DIGITS = 8;
    localparam int W      = 4 * DIGITS;
    localparam int CW     = $clog2(DIGITS + 1);

    // clock / reset
    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    logic          clr, digit_vld, bksp, neg_tgl, load, load_neg;
    logic [3:0]    digit_in;
    logic [W-1:0]  load_val;
    logic [W-1:0]  value;
    logic          neg, full, err;
    logic [CW-1:0] count;

    bcd_entry_register #(.DIGITS(DIGITS)) dut (
        .clk(clk), .rst(rst), .clr(clr), .digit_vld(digit_vld),
        .digit_in(digit_in), .bksp(bksp), .neg_tgl(neg_tgl), .load(load),
        .load_val(load_val), .load_neg(load_neg), .value(value), .neg(neg),
        .count(count), .full(full), .err(err)
    );

    int n_cmp = 0;
    int n_err = 0;

    // model state
    int m_mag;
    bit m_neg;
    bit m_err;

    function automatic int ndig(input int m);
        int n = 0;
        while (m > 0) begin
            m = m / 10;
            n++;
        end
        return n;
    endfunction

    function automatic logic [W-1:0] to_bcd(input int m);
        logic [W-1:0] r = '0;
        for (int i = 0; i < DIGITS; i++) begin
            r[4*i +: 4] = 4'(m % 10);
            m = m / 10;
        end
        return r;
    endfunction

    function automatic bit has_bad(input logic [W-1:0] v);
        for (int i = 0; i < DIGITS; i++)
            if (v[4*i +: 4] > 4'd9) return 1'b1;
        return 1'b0;
    endfunction

    function automatic int from_bcd(input logic [W-1:0] v);
        int r = 0;
        for (int i = DIGITS - 1; i >= 0; i--) r = r * 10 + int'(v[4*i +: 4]);
        return r;
    endfunction

    task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // behavioural reference model
    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_mag = 0;
            m_neg = 1'b0;
            m_err = 1'b0;
        end else begin
            m_err = 1'b0;
            if (clr) begin
                m_mag = 0;
                m_neg = 1'b0;
            end else if (load) begin
                if (has_bad(load_val)) begin
                    m_err = 1'b1;
                end else begin
                    m_mag = from_bcd(load_val);
                    m_neg = load_neg && (m_mag != 0);
                end
            end else begin
                if (bksp) begin
                    m_mag = m_mag / 10;
                end else if (digit_vld) begin
                    if (digit_in > 9 || ndig(m_mag) == DIGITS) m_err = 1'b1;
                    else m_mag = m_mag * 10 + int'(digit_in);
                end
                if (m_mag == 0) m_neg = 1'b0;
                else if (neg_tgl) m_neg = !m_neg;
            end
        end
    end

    // compare process: every cycle, away from the active edge
    always @(negedge clk) begin
        check("value", value, to_bcd(m_mag));
        check("neg", W'(neg), W'(m_neg));
        check("count", W'(count), W'(ndig(m_mag)));
        check("full", W'(full), W'(ndig(m_mag) == DIGITS));
        check("err", W'(err), W'(m_err));
    end

    // driver: apply one cycle of requests, return 1 time unit after the edge
    task automatic op(input bit c, input bit ld, input logic [W-1:0] lv, input bit ln,
                      input bit bk, input bit dv, input logic [3:0] d, input bit tg);
        clr = c; load = ld; load_val = lv; load_neg = ln;
        bksp = bk; digit_vld = dv; digit_in = d; neg_tgl = tg;
        @(posedge clk);
        #1;
        clr = 0; load = 0; load_val = '0; load_neg = 0;
        bksp = 0; digit_vld = 0; digit_in = 4'd0; neg_tgl = 0;
    endtask

    task automatic push(input logic [3:0] d);
        op(0, 0, '0, 0, 0, 1, d, 0);
    endtask

    task automatic idle();
        op(0, 0, '0, 0, 0, 0, 4'd0, 0);
    endtask

    int pw;
    int nd;
    int mm;
    int k;
    int r;
    logic [W-1:0] lv;

    initial begin
        rst = 1'b1;
        clr = 0; load = 0; load_val = '0; load_neg = 0;
        bksp = 0; digit_vld = 0; digit_in = 4'd0; neg_tgl = 0;
        repeat (2) @(posedge clk);
        #1;
        check("reset_value", value, '0);
        check("reset_count", W'(count), '0);
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;

        // 1: push 1,2,3
        push(4'd1); push(4'd2); push(4'd3);
        check("t1_value", value, 32'h0000_0123);
        check("t1_count", W'(count), W'(3));
        check("t1_model", to_bcd(m_mag), 32'h0000_0123);

        // 2: leading zeros, sign, backspace to empty
        op(1, 0, '0, 0, 0, 0, 4'd0, 0);
        push(4'd0); push(4'd0); push(4'd7);
        check("t2_value", value, 32'h0000_0007);
        check("t2_count", W'(count), W'(1));
        op(0, 0, '0, 0, 0, 0, 4'd0, 1);
        check("t2_neg", W'(neg), W'(1));
        op(0, 0, '0, 0, 1, 0, 4'd0, 0);
        check("t2_bksp_count", W'(count), W'(0));
        check("t2_bksp_neg", W'(neg), W'(0));

        // 3: fill with nines, overflow push
        for (int i = 0; i < DIGITS; i++) push(4'd9);
        push(4'd5);
        check("t3_full", W'(full), W'(1));
        check("t3_value", value, 32'h9999_9999);
        check("t3_err", W'(err), W'(1));
        idle();
        check("t3_err_drop", W'(err), W'(0));

        // 4: illegal digit and illegal load nibble
        op(1, 0, '0, 0, 0, 0, 4'd0, 0);
        push(4'd3);
        push(4'hA);
        check("t4_digit_err", W'(err), W'(1));
        check("t4_digit_value", value, 32'h0000_0003);
        op(0, 1, 32'h0000_C000, 1, 0, 0, 4'd0, 0);
        check("t4_load_err", W'(err), W'(1));
        check("t4_load_count", W'(count), W'(1));

        // 5: load wins over bksp and digit push; then clr beats neg_tgl
        op(0, 1, 32'h0000_4020, 1, 1, 1, 4'd5, 0);
        check("t5_value", value, 32'h0000_4020);
        check("t5_count", W'(count), W'(4));
        check("t5_neg", W'(neg), W'(1));
        check("t5_model_neg", W'(m_neg), W'(1));
        op(1, 0, '0, 0, 0, 0, 4'd0, 1);
        check("t5_clr_value", value, '0);
        check("t5_clr_neg", W'(neg), W'(0));

        // random phase
        for (int i = 0; i < 600; i++) begin
            r = $urandom_range(0, 99);
            if (r < 3) begin
                op(1, $urandom_range(0, 1), '0, 1, 1, 1, 4'd1, $urandom_range(0, 1));
            end else if (r < 15) begin
                nd = $urandom_range(0, DIGITS);
                pw = 1;
                for (int j = 0; j < nd; j++) pw = pw * 10;
                mm = (nd == 0) ? 0 : int'($urandom % pw);
                lv = to_bcd(mm);
                if ($urandom_range(0, 3) == 0) begin
                    k = $urandom_range(0, DIGITS - 1);
                    lv[4*k +: 4] = 4'($urandom_range(10, 15));
                end
                op(0, 1, lv, $urandom_range(0, 1), $urandom_range(0, 1),
                   $urandom_range(0, 1), 4'($urandom_range(0, 15)), $urandom_range(0, 1));
            end else if (r < 32) begin
                op(0, 0, '0, 0, 1, $urandom_range(0, 1), 4'($urandom_range(0, 9)),
                   $urandom_range(0, 3) == 0);
            end else if (r < 85) begin
                op(0, 0, '0, 0, 0, 1, 4'($urandom_range(0, 11)), $urandom_range(0, 5) == 0);
            end else begin
                op(0, 0, '0, 0, 0, 0, 4'd0, $urandom_range(0, 1));
            end
        end

        // 6: asynchronous reset between edges
        op(1, 0, '0, 0, 0, 0, 4'd0, 0);
        push(4'd4); push(4'd2);
        #2;
        rst = 1'b1;
        #1;
        check("t6_async_value", value, '0);
        check("t6_async_count", W'(count), '0);
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;
        push(4'd9);
        check("t6_value", value, 32'h0000_0009);
        check("t6_count", W'(count), W'(1));
        idle();

        @(negedge clk);
        #1;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
